// File: rtl/issue_pkg.sv
// Shared decode constants, immediate formats and queue entry layout for the issue stage.
package issue_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [1:0] UNIT_RS  = 2'd0;
  localparam logic [1:0] UNIT_LSB = 2'd1;
  localparam logic [1:0] UNIT_ROB = 2'd2;
  localparam logic [1:0] UNIT_ILL = 2'd3;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_SHAMT,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_LINK
  } imm_fmt_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        rvc;
  } q_entry_t;

  function automatic logic NEEDS_RS1(input logic [6:0] opc);
    return opc inside {OPC_OP, OPC_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JALR};
  endfunction

  function automatic logic NEEDS_RS2(input logic [6:0] opc);
    return opc inside {OPC_OP, OPC_STORE, OPC_BRANCH};
  endfunction

endpackage

// File: rtl/issue_dispatch_queue_if.sv
// Fetch, register-status, backpressure and dispatch bundle of the issue stage.
// master = the issue queue itself, slave = its surrounding units.
interface issue_dispatch_queue_if #(parameter int ROB_ID_W = 5);
  logic                rdy_in;
  logic                flush_in;
  logic                fetch_valid_in;
  logic [31:0]         fetch_inst_in;
  logic [31:0]         fetch_addr_in;
  logic                fetch_rvc_in;
  logic                fetch_ready_out;
  logic [4:0]          reg_rs1_out;
  logic [4:0]          reg_rs2_out;
  logic [ROB_ID_W-1:0] reg_dep1_in;
  logic [ROB_ID_W-1:0] reg_dep2_in;
  logic [31:0]         reg_val1_in;
  logic [31:0]         reg_val2_in;
  logic                rob_full_in;
  logic                rs_full_in;
  logic                lsb_full_in;
  logic [ROB_ID_W-1:0] rob_tail_in;
  logic                disp_valid_out;
  logic [1:0]          disp_unit_out;
  logic [ROB_ID_W-1:0] disp_rob_id_out;
  logic [6:0]          disp_opcode_out;
  logic [2:0]          disp_funct3_out;
  logic                disp_alt_out;
  logic [4:0]          disp_rd_out;
  logic [31:0]         disp_imm_out;
  logic [31:0]         disp_pc_out;
  logic                disp_rvc_out;
  logic [31:0]         disp_v1_out;
  logic [31:0]         disp_v2_out;
  logic [ROB_ID_W-1:0] disp_dep1_out;
  logic [ROB_ID_W-1:0] disp_dep2_out;
  logic                ovf_err_out;

  modport master (
    input  rdy_in, flush_in, fetch_valid_in, fetch_inst_in, fetch_addr_in, fetch_rvc_in,
           reg_dep1_in, reg_dep2_in, reg_val1_in, reg_val2_in,
           rob_full_in, rs_full_in, lsb_full_in, rob_tail_in,
    output fetch_ready_out, reg_rs1_out, reg_rs2_out,
           disp_valid_out, disp_unit_out, disp_rob_id_out, disp_opcode_out, disp_funct3_out,
           disp_alt_out, disp_rd_out, disp_imm_out, disp_pc_out, disp_rvc_out,
           disp_v1_out, disp_v2_out, disp_dep1_out, disp_dep2_out, ovf_err_out
  );

  modport slave (
    output rdy_in, flush_in, fetch_valid_in, fetch_inst_in, fetch_addr_in, fetch_rvc_in,
           reg_dep1_in, reg_dep2_in, reg_val1_in, reg_val2_in,
           rob_full_in, rs_full_in, lsb_full_in, rob_tail_in,
    input  fetch_ready_out, reg_rs1_out, reg_rs2_out,
           disp_valid_out, disp_unit_out, disp_rob_id_out, disp_opcode_out, disp_funct3_out,
           disp_alt_out, disp_rd_out, disp_imm_out, disp_pc_out, disp_rvc_out,
           disp_v1_out, disp_v2_out, disp_dep1_out, disp_dep2_out, ovf_err_out
  );
endinterface

// File: rtl/inst_field_decode.sv
// Combinational RV32 field decode of the queue head: target unit, register fields, immediate.
// Zero latency, no state; backpressure is resolved by the caller.
module inst_field_decode
  import issue_pkg::*;
(
  input  logic [31:0] i_inst,
  input  logic        i_rvc,
  output logic [1:0]  o_unit,
  output logic [6:0]  o_opcode,
  output logic [4:0]  o_rd,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic [2:0]  o_funct3,
  output logic        o_alt,
  output logic [31:0] o_imm,
  output logic        o_use1,
  output logic        o_use2
);

  imm_fmt_e w_fmt;

  assign o_opcode = i_inst[6:0];
  assign o_funct3 = i_inst[14:12];
  assign o_alt    = i_inst[30];
  assign o_rs1    = i_inst[19:15];
  assign o_rs2    = i_inst[24:20];
  assign o_use1   = NEEDS_RS1(o_opcode);
  assign o_use2   = NEEDS_RS2(o_opcode);
  assign o_rd     = (o_opcode == OPC_BRANCH || o_opcode == OPC_STORE) ? 5'd0 : i_inst[11:7];

  always_comb begin
    o_unit = UNIT_ILL;
    w_fmt  = IMM_NONE;
    case (o_opcode)
      OPC_LOAD:   begin o_unit = UNIT_LSB; w_fmt = IMM_I; end
      OPC_STORE:  begin o_unit = UNIT_LSB; w_fmt = IMM_S; end
      OPC_OP:     begin o_unit = UNIT_RS;  w_fmt = IMM_NONE; end
      // SLLI/SRLI/SRAI carry funct7 in the upper bits, so only the shamt is the immediate
      OPC_IMM:    begin o_unit = UNIT_RS;  w_fmt = (i_inst[13:12] == 2'b01) ? IMM_SHAMT : IMM_I; end
      OPC_BRANCH: begin o_unit = UNIT_RS;  w_fmt = IMM_B; end
      OPC_JAL:    begin o_unit = UNIT_RS;  w_fmt = IMM_LINK; end
      OPC_JALR:   begin o_unit = UNIT_RS;  w_fmt = IMM_I; end
      OPC_AUIPC:  begin o_unit = UNIT_RS;  w_fmt = IMM_U; end
      OPC_LUI:    begin o_unit = UNIT_ROB; w_fmt = IMM_U; end
      default:    begin o_unit = UNIT_ILL; w_fmt = IMM_NONE; end
    endcase
  end

  always_comb begin
    o_imm = 32'd0;
    case (w_fmt)
      IMM_I:     o_imm = {{20{i_inst[31]}}, i_inst[31:20]};
      IMM_SHAMT: o_imm = {27'd0, i_inst[24:20]};
      IMM_S:     o_imm = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
      IMM_B:     o_imm = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
      IMM_U:     o_imm = {i_inst[31:12], 12'd0};
      IMM_LINK:  o_imm = i_rvc ? 32'd2 : 32'd4;
      default:   o_imm = 32'd0;
    endcase
  end

endmodule

// File: rtl/issue_dispatch_queue.sv
// Circular instruction queue feeding a registered dispatch bundle: enqueue-to-dispatch is 2 edges.
// Head stalls only on rob_full_in and the selected unit's full flag; fetch_ready_out keeps AF_MARGIN slack.
module issue_dispatch_queue
  import issue_pkg::*;
#(
  parameter int DEPTH     = 32,
  parameter int ROB_ID_W  = 5,
  parameter int AF_MARGIN = 1
) (
  input logic                   clk_in,
  input logic                   rst_in,
  issue_dispatch_queue_if.master bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] AF_LIMIT = (PTR_W+1)'(DEPTH - 1 - AF_MARGIN);

  q_entry_t            r_mem [DEPTH];
  logic [PTR_W-1:0]    r_head;
  logic [PTR_W-1:0]    r_tail;
  logic [PTR_W:0]      r_count;
  logic                r_ovf;
  logic                r_disp_valid;
  logic [1:0]          r_unit;
  logic [ROB_ID_W-1:0] r_rob_id;
  logic [6:0]          r_opcode;
  logic [2:0]          r_funct3;
  logic                r_alt;
  logic [4:0]          r_rd;
  logic [31:0]         r_imm;
  logic [31:0]         r_pc;
  logic                r_rvc;
  logic [31:0]         r_v1;
  logic [31:0]         r_v2;
  logic [ROB_ID_W-1:0] r_dep1;
  logic [ROB_ID_W-1:0] r_dep2;

  q_entry_t            w_head;
  logic [1:0]          w_unit;
  logic [6:0]          w_opcode;
  logic [4:0]          w_rd;
  logic [2:0]          w_funct3;
  logic                w_alt;
  logic [31:0]         w_imm;
  logic                w_use1;
  logic                w_use2;
  logic                w_tgt_full;
  logic                w_pop;
  logic                w_push;
  logic                w_ovf_set;
  logic [ROB_ID_W-1:0] w_rob_id;
  logic [ROB_ID_W-1:0] w_dep1;
  logic [ROB_ID_W-1:0] w_dep2;
  logic [31:0]         w_v1;
  logic [31:0]         w_v2;

  assign w_head = r_mem[r_head];

  inst_field_decode u_decode (
    .i_inst   (w_head.inst),
    .i_rvc    (w_head.rvc),
    .o_unit   (w_unit),
    .o_opcode (w_opcode),
    .o_rd     (w_rd),
    .o_rs1    (bus.reg_rs1_out),
    .o_rs2    (bus.reg_rs2_out),
    .o_funct3 (w_funct3),
    .o_alt    (w_alt),
    .o_imm    (w_imm),
    .o_use1   (w_use1),
    .o_use2   (w_use2)
  );

  always_comb begin
    w_tgt_full = 1'b0;
    case (w_unit)
      UNIT_RS:  w_tgt_full = bus.rs_full_in;
      UNIT_LSB: w_tgt_full = bus.lsb_full_in;
      default:  w_tgt_full = 1'b0;
    endcase
  end

  assign w_pop     = (r_count != '0) && !bus.rob_full_in && !w_tgt_full;
  assign w_push    = bus.fetch_valid_in && (r_count != FULL_CNT);
  assign w_ovf_set = bus.fetch_valid_in && (r_count == FULL_CNT);

  // A dispatch last cycle means the ROB has not yet advanced its tail past that id
  assign w_rob_id = !r_disp_valid                          ? bus.rob_tail_in :
                    (bus.rob_tail_in == {ROB_ID_W{1'b1}}) ? ROB_ID_W'(1)    :
                                                            bus.rob_tail_in + 1'b1;

  assign w_dep1 = w_use1 ? bus.reg_dep1_in : '0;
  assign w_dep2 = w_use2 ? bus.reg_dep2_in : '0;
  assign w_v1   = (w_opcode == OPC_JAL || w_opcode == OPC_AUIPC) ? w_head.pc :
                  (w_use1 && bus.reg_dep1_in == '0)             ? bus.reg_val1_in : 32'd0;
  assign w_v2   = (w_use2 && bus.reg_dep2_in == '0) ? bus.reg_val2_in : 32'd0;

  always_ff @(posedge clk_in) begin
    if (bus.rdy_in && !bus.flush_in && w_push) begin
      r_mem[r_tail] <= '{inst: bus.fetch_inst_in, pc: bus.fetch_addr_in, rvc: bus.fetch_rvc_in};
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_ovf        <= 1'b0;
      r_disp_valid <= 1'b0;
      r_unit       <= '0;
      r_rob_id     <= '0;
      r_opcode     <= '0;
      r_funct3     <= '0;
      r_alt        <= 1'b0;
      r_rd         <= '0;
      r_imm        <= '0;
      r_pc         <= '0;
      r_rvc        <= 1'b0;
      r_v1         <= '0;
      r_v2         <= '0;
      r_dep1       <= '0;
      r_dep2       <= '0;
    end else if (bus.rdy_in) begin
      if (bus.flush_in) begin
        r_head       <= '0;
        r_tail       <= '0;
        r_count      <= '0;
        r_disp_valid <= 1'b0;
      end else begin
        if (w_push) r_tail <= r_tail + 1'b1;
        if (w_pop)  r_head <= r_head + 1'b1;
        if (w_push && !w_pop)      r_count <= r_count + 1'b1;
        else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        if (w_ovf_set) r_ovf <= 1'b1;
        r_disp_valid <= w_pop;
        if (w_pop) begin
          r_unit   <= w_unit;
          r_rob_id <= w_rob_id;
          r_opcode <= w_opcode;
          r_funct3 <= w_funct3;
          r_alt    <= w_alt;
          r_rd     <= w_rd;
          r_imm    <= w_imm;
          r_pc     <= w_head.pc;
          r_rvc    <= w_head.rvc;
          r_v1     <= w_v1;
          r_v2     <= w_v2;
          r_dep1   <= w_dep1;
          r_dep2   <= w_dep2;
        end
      end
    end
  end

  assign bus.fetch_ready_out = (r_count <= AF_LIMIT);
  assign bus.ovf_err_out     = r_ovf;
  assign bus.disp_valid_out  = r_disp_valid;
  assign bus.disp_unit_out   = r_unit;
  assign bus.disp_rob_id_out = r_rob_id;
  assign bus.disp_opcode_out = r_opcode;
  assign bus.disp_funct3_out = r_funct3;
  assign bus.disp_alt_out    = r_alt;
  assign bus.disp_rd_out     = r_rd;
  assign bus.disp_imm_out    = r_imm;
  assign bus.disp_pc_out     = r_pc;
  assign bus.disp_rvc_out    = r_rvc;
  assign bus.disp_v1_out     = r_v1;
  assign bus.disp_v2_out     = r_v2;
  assign bus.disp_dep1_out   = r_dep1;
  assign bus.disp_dep2_out   = r_dep2;

endmodule

// File: tb/tb_issue_dispatch_queue.sv
// Directed bench for issue_dispatch_queue: hand-encoded RV32 words with hand-computed dispatch fields.
module tb_issue_dispatch_queue;

  localparam logic [31:0] I_ADDI = 32'h00500093;  // addi x1,x0,5
  localparam logic [31:0] I_LUI  = 32'h123452B7;  // lui  x5,0x12345
  localparam logic [31:0] I_SRAI = 32'h4030D093;  // srai x1,x1,3
  localparam logic [31:0] I_SW   = 32'h0020A423;  // sw   x2,8(x1)
  localparam logic [31:0] I_ADD  = 32'h005201B3;  // add  x3,x4,x5
  localparam logic [31:0] I_BEQ  = 32'hFE208CE3;  // beq  x1,x2,-8
  localparam logic [31:0] I_JAL  = 32'h008000EF;  // jal  x1,8

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  issue_dispatch_queue_if #(.ROB_ID_W(5)) bus ();

  issue_dispatch_queue #(.DEPTH(32), .ROB_ID_W(5), .AF_MARGIN(1)) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_fetch(input logic [31:0] inst, input logic [31:0] pc, input logic rvc);
    bus.fetch_valid_in = 1'b1;
    bus.fetch_inst_in  = inst;
    bus.fetch_addr_in  = pc;
    bus.fetch_rvc_in   = rvc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.rdy_in = 1'b1; bus.flush_in = 1'b0; bus.fetch_valid_in = 1'b0;
    bus.fetch_inst_in = '0; bus.fetch_addr_in = '0; bus.fetch_rvc_in = 1'b0;
    bus.reg_dep1_in = '0; bus.reg_dep2_in = '0; bus.reg_val1_in = '0; bus.reg_val2_in = '0;
    bus.rob_full_in = 1'b0; bus.rs_full_in = 1'b0; bus.lsb_full_in = 1'b0; bus.rob_tail_in = '0;
    step(); step();
    checks++; if (bus.disp_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h exp 0", bus.disp_valid_out); end
    checks++; if (bus.ovf_err_out !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0h exp 0", bus.ovf_err_out); end
    checks++; if (bus.fetch_ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready got %0h exp 1", bus.fetch_ready_out); end
    checks++; if (bus.disp_imm_out !== 32'h0 || bus.disp_rob_id_out !== 5'd0) begin errors++; $display("FAIL reset_fields got imm %h id %0d exp 0 0", bus.disp_imm_out, bus.disp_rob_id_out); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_addi();
    bus.rob_tail_in = 5'd3;
    drive_fetch(I_ADDI, 32'h100, 1'b0);
    step();
    bus.fetch_valid_in = 1'b0;
    checks++; if (bus.disp_valid_out !== 1'b0) begin errors++; $display("FAIL addi_early got %0h exp 0", bus.disp_valid_out); end
    step();
    checks++; if (bus.disp_valid_out !== 1'b1) begin errors++; $display("FAIL addi_valid got %0h exp 1", bus.disp_valid_out); end
    checks++; if (bus.disp_unit_out !== 2'd0) begin errors++; $display("FAIL addi_unit got %0d exp 0", bus.disp_unit_out); end
    checks++; if (bus.disp_rob_id_out !== 5'd3) begin errors++; $display("FAIL addi_robid got %0d exp 3", bus.disp_rob_id_out); end
    checks++; if (bus.disp_imm_out !== 32'd5) begin errors++; $display("FAIL addi_imm got %h exp 5", bus.disp_imm_out); end
    checks++; if (bus.disp_v1_out !== 32'd0 || bus.disp_dep1_out !== 5'd0) begin errors++; $display("FAIL addi_op1 got v1 %h dep1 %0d exp 0 0", bus.disp_v1_out, bus.disp_dep1_out); end
    checks++; if (bus.disp_rd_out !== 5'd1 || bus.disp_pc_out !== 32'h100) begin errors++; $display("FAIL addi_rd_pc got rd %0d pc %h exp 1 100", bus.disp_rd_out, bus.disp_pc_out); end
    step();
    checks++; if (bus.disp_valid_out !== 1'b0) begin errors++; $display("FAIL addi_strobe got %0h exp 0", bus.disp_valid_out); end
  endtask

  task automatic test_back_to_back();
    bus.rob_tail_in = 5'd31;
    drive_fetch(I_LUI, 32'h200, 1'b0);
    step();
    drive_fetch(I_SRAI, 32'h204, 1'b0);
    step();
    bus.fetch_valid_in = 1'b0;
    checks++; if (bus.disp_valid_out !== 1'b1 || bus.disp_rob_id_out !== 5'd31) begin errors++; $display("FAIL b2b_first got v %0h id %0d exp 1 31", bus.disp_valid_out, bus.disp_rob_id_out); end
    checks++; if (bus.disp_unit_out !== 2'd2 || bus.disp_imm_out !== 32'h12345000 || bus.disp_rd_out !== 5'd5) begin errors++; $display("FAIL b2b_lui got unit %0d imm %h rd %0d exp 2 12345000 5", bus.disp_unit_out, bus.disp_imm_out, bus.disp_rd_out); end
    step();
    checks++; if (bus.disp_valid_out !== 1'b1 || bus.disp_rob_id_out !== 5'd1) begin errors++; $display("FAIL b2b_wrap got v %0h id %0d exp 1 1", bus.disp_valid_out, bus.disp_rob_id_out); end
    checks++; if (bus.disp_imm_out !== 32'd3 || bus.disp_alt_out !== 1'b1 || bus.disp_funct3_out !== 3'd5) begin errors++; $display("FAIL b2b_srai got imm %h alt %0h f3 %0d exp 3 1 5", bus.disp_imm_out, bus.disp_alt_out, bus.disp_funct3_out); end
    step();
    checks++; if (bus.disp_valid_out !== 1'b0) begin errors++; $display("FAIL b2b_idle got %0h exp 0", bus.disp_valid_out); end
  endtask

  task automatic test_lsb_stall();
    bus.rob_tail_in = 5'd4;
    bus.lsb_full_in = 1'b1;
    drive_fetch(I_SW, 32'h300, 1'b0);
    step();
    drive_fetch(I_ADD, 32'h304, 1'b0);
    step();
    bus.fetch_valid_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.disp_valid_out !== 1'b0 || bus.reg_rs1_out !== 5'd1) begin errors++; $display("FAIL lsb_stall%0d got v %0h rs1 %0d exp 0 1", i, bus.disp_valid_out, bus.reg_rs1_out); end
      step();
    end
    bus.reg_val1_in = 32'h1000;
    bus.reg_val2_in = 32'h55;
    bus.lsb_full_in = 1'b0;
    step();
    checks++; if (bus.disp_valid_out !== 1'b1 || bus.disp_unit_out !== 2'd1 || bus.disp_opcode_out !== 7'h23) begin errors++; $display("FAIL sw_disp got v %0h unit %0d opc %h exp 1 1 23", bus.disp_valid_out, bus.disp_unit_out, bus.disp_opcode_out); end
    checks++; if (bus.disp_imm_out !== 32'd8 || bus.disp_rd_out !== 5'd0 || bus.disp_rob_id_out !== 5'd4) begin errors++; $display("FAIL sw_fields got imm %h rd %0d id %0d exp 8 0 4", bus.disp_imm_out, bus.disp_rd_out, bus.disp_rob_id_out); end
    checks++; if (bus.disp_v1_out !== 32'h1000 || bus.disp_v2_out !== 32'h55) begin errors++; $display("FAIL sw_vals got %h %h exp 1000 55", bus.disp_v1_out, bus.disp_v2_out); end
    step();
    checks++; if (bus.disp_valid_out !== 1'b1 || bus.disp_unit_out !== 2'd0 || bus.disp_rd_out !== 5'd3 || bus.disp_rob_id_out !== 5'd5) begin errors++; $display("FAIL add_disp got v %0h unit %0d rd %0d id %0d exp 1 0 3 5", bus.disp_valid_out, bus.disp_unit_out, bus.disp_rd_out, bus.disp_rob_id_out); end
    step();
    bus.reg_val1_in = '0;
    bus.reg_val2_in = '0;
  endtask

  task automatic test_operands();
    bus.rob_tail_in = 5'd10;
    drive_fetch(I_BEQ, 32'h80, 1'b0);
    step();
    drive_fetch(I_JAL, 32'h40, 1'b1);
    bus.reg_dep1_in = 5'd7; bus.reg_val1_in = 32'hDEAD;
    bus.reg_dep2_in = 5'd0; bus.reg_val2_in = 32'h1234;
    step();
    bus.fetch_valid_in = 1'b0;
    bus.reg_dep2_in = 5'd9;
    checks++; if (bus.disp_dep1_out !== 5'd7 || bus.disp_v1_out !== 32'd0) begin errors++; $display("FAIL beq_op1 got dep %0d v1 %h exp 7 0", bus.disp_dep1_out, bus.disp_v1_out); end
    checks++; if (bus.disp_dep2_out !== 5'd0 || bus.disp_v2_out !== 32'h1234) begin errors++; $display("FAIL beq_op2 got dep %0d v2 %h exp 0 1234", bus.disp_dep2_out, bus.disp_v2_out); end
    checks++; if (bus.disp_rd_out !== 5'd0 || bus.disp_imm_out !== 32'hFFFFFFF8 || bus.disp_rob_id_out !== 5'd10) begin errors++; $display("FAIL beq_fields got rd %0d imm %h id %0d exp 0 fffffff8 10", bus.disp_rd_out, bus.disp_imm_out, bus.disp_rob_id_out); end
    step();
    checks++; if (bus.disp_v1_out !== 32'h40 || bus.disp_imm_out !== 32'd2 || bus.disp_rvc_out !== 1'b1) begin errors++; $display("FAIL jal_fields got v1 %h imm %h rvc %0h exp 40 2 1", bus.disp_v1_out, bus.disp_imm_out, bus.disp_rvc_out); end
    checks++; if (bus.disp_dep1_out !== 5'd0 || bus.disp_dep2_out !== 5'd0 || bus.disp_v2_out !== 32'd0) begin errors++; $display("FAIL jal_unused got d1 %0d d2 %0d v2 %h exp 0 0 0", bus.disp_dep1_out, bus.disp_dep2_out, bus.disp_v2_out); end
    checks++; if (bus.disp_rd_out !== 5'd1 || bus.disp_rob_id_out !== 5'd11) begin errors++; $display("FAIL jal_id got rd %0d id %0d exp 1 11", bus.disp_rd_out, bus.disp_rob_id_out); end
    bus.rdy_in = 1'b0;
    step(); step();
    checks++; if (bus.disp_valid_out !== 1'b1 || bus.disp_rob_id_out !== 5'd11) begin errors++; $display("FAIL rdy_hold got v %0h id %0d exp 1 11", bus.disp_valid_out, bus.disp_rob_id_out); end
    bus.rdy_in = 1'b1;
    step();
    checks++; if (bus.disp_valid_out !== 1'b0) begin errors++; $display("FAIL rdy_resume got %0h exp 0", bus.disp_valid_out); end
    bus.reg_dep1_in = '0; bus.reg_dep2_in = '0; bus.reg_val1_in = '0; bus.reg_val2_in = '0;
  endtask

  task automatic test_fill();
    bus.rob_full_in = 1'b1;
    drive_fetch(I_ADDI, 32'h500, 1'b0);
    for (int i = 0; i <= 32; i++) begin
      checks++; if (bus.fetch_ready_out !== (i <= 30)) begin errors++; $display("FAIL fill_ready%0d got %0h exp %0h", i, bus.fetch_ready_out, (i <= 30)); end
      if (i == 32) begin
        checks++; if (bus.ovf_err_out !== 1'b0) begin errors++; $display("FAIL fill_noovf got %0h exp 0", bus.ovf_err_out); end
      end
      step();
    end
    bus.fetch_valid_in = 1'b0;
    checks++; if (bus.ovf_err_out !== 1'b1) begin errors++; $display("FAIL fill_ovf got %0h exp 1", bus.ovf_err_out); end
    checks++; if (dut.r_count !== 6'd32) begin errors++; $display("FAIL fill_count got %0d exp 32", dut.r_count); end
    bus.flush_in = 1'b1;
    step();
    bus.flush_in = 1'b0;
    bus.rob_full_in = 1'b0;
    checks++; if (bus.fetch_ready_out !== 1'b1 || bus.ovf_err_out !== 1'b1) begin errors++; $display("FAIL fill_flush got rdy %0h ovf %0h exp 1 1", bus.fetch_ready_out, bus.ovf_err_out); end
  endtask

  task automatic test_flush();
    drive_fetch(I_ADDI, 32'h600, 1'b0);
    step();
    drive_fetch(I_LUI, 32'h604, 1'b0);
    bus.flush_in = 1'b1;
    step();
    bus.flush_in = 1'b0;
    bus.fetch_valid_in = 1'b0;
    checks++; if (bus.disp_valid_out !== 1'b0 || dut.r_count !== 6'd0) begin errors++; $display("FAIL flush_state got v %0h cnt %0d exp 0 0", bus.disp_valid_out, dut.r_count); end
    checks++; if (bus.ovf_err_out !== 1'b1) begin errors++; $display("FAIL flush_ovf got %0h exp 1", bus.ovf_err_out); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.disp_valid_out !== 1'b0) begin errors++; $display("FAIL flush_drop%0d got %0h exp 0", i, bus.disp_valid_out); end
    end
  endtask

  task automatic test_reset_mid();
    bus.rob_tail_in = 5'd6;
    drive_fetch(I_ADDI, 32'h700, 1'b0);
    step();
    bus.fetch_valid_in = 1'b0;
    step();
    checks++; if (bus.disp_valid_out !== 1'b1 || bus.disp_rob_id_out !== 5'd6) begin errors++; $display("FAIL mid_pre got v %0h id %0d exp 1 6", bus.disp_valid_out, bus.disp_rob_id_out); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus.disp_valid_out !== 1'b0 || bus.disp_rob_id_out !== 5'd0 || bus.disp_pc_out !== 32'd0) begin errors++; $display("FAIL mid_async got v %0h id %0d pc %h exp 0 0 0", bus.disp_valid_out, bus.disp_rob_id_out, bus.disp_pc_out); end
    checks++; if (bus.ovf_err_out !== 1'b0) begin errors++; $display("FAIL mid_ovf got %0h exp 0", bus.ovf_err_out); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_addi();
    test_back_to_back();
    test_lsb_stall();
    test_operands();
    test_fill();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
